// File: rtl/irrigation_scheduler.sv
// Irrigation valve scheduler: periodic sensor sampling, fuzzy-result capture,
// timed irrigation with rain abort, manual override and an enforced off-time.
module irrigation_scheduler #(
    parameter int TICK_DIV      = 1000,
    parameter int SAMPLE_PERIOD = 60,
    parameter int SETTLE_CYCLES = 4,
    parameter int MIN_OFF       = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] irrigation_time,
    input  logic       rain_present,
    input  logic       sample_done,
    input  logic       manual_req,
    input  logic [7:0] manual_time,
    output logic       sample_req,
    output logic       valve_on,
    output logic [7:0] remaining,
    output logic [2:0] state,
    output logic       cycle_done,
    output logic [7:0] abort_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAMPLE   = 3'd1,
        SETTLE   = 3'd2,
        IRRIGATE = 3'd3,
        COOLDOWN = 3'd4
    } state_t;

    localparam int PRESC_W  = (TICK_DIV > 1)      ? $clog2(TICK_DIV)      : 1;
    localparam int PERIOD_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int OFF_W    = (MIN_OFF > 1)       ? $clog2(MIN_OFF)       : 1;

    localparam logic [PRESC_W-1:0]  PRESC_LAST  = PRESC_W'(TICK_DIV - 1);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(SAMPLE_PERIOD - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [OFF_W-1:0]    OFF_LAST    = OFF_W'(MIN_OFF - 1);

    state_t              state_q,      state_d;
    logic [PRESC_W-1:0]  presc_q,      presc_d;
    logic [PERIOD_W-1:0] period_q,     period_d;
    logic [SETTLE_W-1:0] settle_q,     settle_d;
    logic [OFF_W-1:0]    off_q,        off_d;
    logic [7:0]          remaining_q,  remaining_d;
    logic [7:0]          abort_q,      abort_d;
    logic                manual_q,     manual_d;
    logic                valve_q,      valve_d;
    logic                sampleReq_q,  sampleReq_d;
    logic                cycleDone_q,  cycleDone_d;
    logic                tick;

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            period_q    <= '0;
            settle_q    <= '0;
            off_q       <= '0;
            remaining_q <= '0;
            abort_q     <= '0;
            manual_q    <= 1'b0;
            valve_q     <= 1'b0;
            sampleReq_q <= 1'b0;
            cycleDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            period_q    <= period_d;
            settle_q    <= settle_d;
            off_q       <= off_d;
            remaining_q <= remaining_d;
            abort_q     <= abort_d;
            manual_q    <= manual_d;
            valve_q     <= valve_d;
            sampleReq_q <= sampleReq_d;
            cycleDone_q <= cycleDone_d;
        end
    end

    // Period, settle and off-time counters read as zero outside their own state.
    always_comb begin
        state_d     = state_q;
        period_d    = '0;
        settle_d    = '0;
        off_d       = '0;
        remaining_d = remaining_q;
        abort_d     = abort_q;
        manual_d    = manual_q;
        cycleDone_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (manual_req && (manual_time != 8'd0) && !rain_present) begin
                    state_d     = IRRIGATE;
                    remaining_d = manual_time;
                    manual_d    = 1'b1;
                end else if (enable) begin
                    period_d = period_q;
                    if (tick) begin
                        if (period_q == PERIOD_LAST) begin
                            state_d  = SAMPLE;
                            period_d = '0;
                        end else begin
                            period_d = period_q + 1'b1;
                        end
                    end
                end
            end

            SAMPLE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (sample_done) begin
                    state_d = SETTLE;
                end
            end

            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    if (rain_present || (irrigation_time == 8'd0)) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = IRRIGATE;
                        remaining_d = irrigation_time;
                        manual_d    = 1'b0;
                    end
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end

            // Rain wins over both the enable drop and a coinciding final tick.
            IRRIGATE: begin
                if (rain_present) begin
                    state_d     = COOLDOWN;
                    remaining_d = '0;
                    if (abort_q != 8'hFF) begin
                        abort_d = abort_q + 8'd1;
                    end
                end else if (!enable && !manual_q) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                end else if (tick) begin
                    if (remaining_q == 8'd1) begin
                        state_d     = COOLDOWN;
                        remaining_d = '0;
                        cycleDone_d = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 8'd1;
                    end
                end
            end

            COOLDOWN: begin
                off_d = off_q;
                if (tick) begin
                    if (off_q == OFF_LAST) begin
                        state_d = IDLE;
                        off_d   = '0;
                    end else begin
                        off_d = off_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                remaining_d = '0;
                manual_d    = 1'b0;
            end
        endcase
    end

    // Restarting the prescaler on entry makes irrigation and off-time exact multiples of TICK_DIV.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        if ((state_d != state_q) && ((state_d == IRRIGATE) || (state_d == COOLDOWN))) begin
            presc_d = '0;
        end
        valve_d     = (state_d == IRRIGATE);
        sampleReq_d = (state_d == SAMPLE) && (state_q != SAMPLE);
    end

    assign sample_req  = sampleReq_q;
    assign valve_on    = valve_q;
    assign remaining   = remaining_q;
    assign state       = state_q;
    assign cycle_done  = cycleDone_q;
    assign abort_count = abort_q;

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Directed-sequence bench for irrigation_scheduler with randomized durations and
// abort points, checked against timing and abort-count expectations computed here.
module tb_irrigation_scheduler;

    localparam int TICK_DIV      = 4;
    localparam int SAMPLE_PERIOD = 3;
    localparam int SETTLE_CYCLES = 4;
    localparam int MIN_OFF       = 2;
    localparam int PERIOD_CYCLES = TICK_DIV * SAMPLE_PERIOD;
    localparam int OFF_CYCLES    = TICK_DIV * MIN_OFF;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] irrigation_time;
    logic       rain_present;
    logic       sample_done;
    logic       manual_req;
    logic [7:0] manual_time;
    logic       sample_req;
    logic       valve_on;
    logic [7:0] remaining;
    logic [2:0] state;
    logic       cycle_done;
    logic [7:0] abort_count;

    int testsRun    = 0;
    int testsFailed = 0;
    int modelAborts = 0;

    irrigation_scheduler #(
        .TICK_DIV      (TICK_DIV),
        .SAMPLE_PERIOD (SAMPLE_PERIOD),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .MIN_OFF       (MIN_OFF)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .irrigation_time (irrigation_time),
        .rain_present    (rain_present),
        .sample_done     (sample_done),
        .manual_req      (manual_req),
        .manual_time     (manual_time),
        .sample_req      (sample_req),
        .valve_on        (valve_on),
        .remaining       (remaining),
        .state           (state),
        .cycle_done      (cycle_done),
        .abort_count     (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] itime, input logic rain);
        enable          = en;
        irrigation_time = itime;
        rain_present    = rain;
    endtask

    task automatic pulseSampleDone();
        sample_done = 1'b1;
        cyc();
        sample_done = 1'b0;
    endtask

    task automatic pulseManual(input logic [7:0] mtime);
        manual_req  = 1'b1;
        manual_time = mtime;
        cyc();
        manual_req  = 1'b0;
    endtask

    task automatic waitSampleReq(input int limit, output int n);
        n = 0;
        while (sample_req !== 1'b1 && n < limit) begin cyc(); n++; end
    endtask

    task automatic waitValve(input logic val, input int limit, output int n);
        n = 0;
        while (valve_on !== val && n < limit) begin cyc(); n++; end
    endtask

    task automatic waitState(input logic [2:0] s, input int limit, output int n);
        n = 0;
        while (state !== s && n < limit) begin cyc(); n++; end
    endtask

    task automatic waitRemaining(input logic [7:0] r, input int limit, output int n);
        n = 0;
        while (remaining !== r && n < limit) begin cyc(); n++; end
    endtask

    initial begin
        int n;
        int t1, t2, r, m, abortAt;
        logic valveSeen;

        reset       = 1'b1;
        sample_done = 1'b0;
        manual_req  = 1'b0;
        manual_time = 8'd0;
        applyStimulus(1'b0, 8'd0, 1'b0);
        repeat (2) cyc();
        checkOutput("reset_state", 32'(state), 0);
        checkOutput("reset_valve", 32'(valve_on), 0);
        checkOutput("reset_remaining", 32'(remaining), 0);
        checkOutput("reset_aborts", 32'(abort_count), 0);
        checkOutput("reset_sreq", 32'(sample_req), 0);

        // Automatic cycle with a random irrigation time
        t1 = $urandom_range(1, 8);
        reset = 1'b0;
        applyStimulus(1'b1, 8'(t1), 1'b0);
        waitSampleReq(40, n);
        checkOutput("sreq_latency", 32'(n), 32'(PERIOD_CYCLES));
        checkOutput("sample_state", 32'(state), 1);
        pulseSampleDone();
        checkOutput("sreq_single", 32'(sample_req), 0);
        checkOutput("settle_state", 32'(state), 2);
        waitValve(1'b1, 20, n);
        checkOutput("settle_latency", 32'(n + 1), 32'(SETTLE_CYCLES + 1));
        checkOutput("auto_remaining", 32'(remaining), 32'(t1));
        checkOutput("auto_state", 32'(state), 3);
        waitValve(1'b0, 100, n);
        checkOutput("auto_valve_cycles", 32'(n), 32'(t1 * TICK_DIV));
        checkOutput("auto_cycle_done", 32'(cycle_done), 1);
        checkOutput("auto_cooldown", 32'(state), 4);
        cyc();
        checkOutput("cycle_done_single", 32'(cycle_done), 0);
        waitState(3'd0, 40, n);
        checkOutput("cooldown_cycles", 32'(n + 1), 32'(OFF_CYCLES));

        // Automatic cycle aborted by rain at a random remaining count
        t2 = $urandom_range(3, 9);
        applyStimulus(1'b1, 8'(t2), 1'b0);
        waitSampleReq(40, n);
        checkOutput("sreq_latency2", 32'(n), 32'(PERIOD_CYCLES));
        pulseSampleDone();
        waitValve(1'b1, 20, n);
        r = $urandom_range(1, t2);
        waitRemaining(8'(r), 100, n);
        checkOutput("rem_reached", 32'(remaining), 32'(r));
        applyStimulus(1'b1, 8'(t2), 1'b1);
        cyc();
        applyStimulus(1'b1, 8'(t2), 1'b0);
        modelAborts = (modelAborts < 255) ? modelAborts + 1 : 255;
        checkOutput("rain_valve", 32'(valve_on), 0);
        checkOutput("rain_state", 32'(state), 4);
        checkOutput("rain_aborts", 32'(abort_count), 32'(modelAborts));
        checkOutput("rain_no_done", 32'(cycle_done), 0);
        checkOutput("rain_remaining", 32'(remaining), 0);
        waitState(3'd0, 40, n);

        // Zero result and rain at the latch both return to IDLE without irrigation
        applyStimulus(1'b1, 8'd0, 1'b0);
        waitSampleReq(40, n);
        pulseSampleDone();
        valveSeen = 1'b0;
        for (int i = 0; i < 8; i++) begin cyc(); valveSeen |= valve_on; end
        checkOutput("zero_time_valve", 32'(valveSeen), 0);
        checkOutput("zero_time_state", 32'(state), 0);
        applyStimulus(1'b1, 8'd7, 1'b0);
        waitSampleReq(40, n);
        applyStimulus(1'b1, 8'd7, 1'b1);
        pulseSampleDone();
        valveSeen = 1'b0;
        for (int i = 0; i < 8; i++) begin cyc(); valveSeen |= valve_on; end
        applyStimulus(1'b1, 8'd7, 1'b0);
        checkOutput("latch_rain_valve", 32'(valveSeen), 0);
        checkOutput("latch_rain_state", 32'(state), 0);
        checkOutput("latch_rain_aborts", 32'(abort_count), 32'(modelAborts));

        // Dropping enable in SAMPLE and in an automatic IRRIGATE
        waitSampleReq(40, n);
        applyStimulus(1'b0, 8'd6, 1'b0);
        cyc();
        checkOutput("sample_disable", 32'(state), 0);
        applyStimulus(1'b1, 8'd6, 1'b0);
        waitSampleReq(40, n);
        pulseSampleDone();
        waitValve(1'b1, 20, n);
        repeat (2) cyc();
        applyStimulus(1'b0, 8'd6, 1'b0);
        cyc();
        checkOutput("irr_disable_state", 32'(state), 0);
        checkOutput("irr_disable_valve", 32'(valve_on), 0);
        checkOutput("irr_disable_rem", 32'(remaining), 0);
        checkOutput("irr_disable_aborts", 32'(abort_count), 32'(modelAborts));

        // Manual requests with enable low
        m = $urandom_range(1, 6);
        pulseManual(8'(m));
        checkOutput("manual_state", 32'(state), 3);
        checkOutput("manual_remaining", 32'(remaining), 32'(m));
        waitValve(1'b0, 100, n);
        checkOutput("manual_valve_cycles", 32'(n), 32'(m * TICK_DIV));
        checkOutput("manual_cycle_done", 32'(cycle_done), 1);
        pulseManual(8'd5);
        checkOutput("manual_in_cooldown", 32'(state), 4);
        checkOutput("manual_in_cooldown_valve", 32'(valve_on), 0);
        waitState(3'd0, 40, n);
        pulseManual(8'd0);
        checkOutput("manual_zero", 32'(state), 0);
        applyStimulus(1'b0, 8'd0, 1'b1);
        pulseManual(8'd3);
        applyStimulus(1'b0, 8'd0, 1'b0);
        checkOutput("manual_rain", 32'(state), 0);
        pulseManual(8'd2);
        waitValve(1'b0, 40, n);
        checkOutput("manual2_cycles", 32'(n), 32'(2 * TICK_DIV));
        waitState(3'd0, 40, n);

        // Rain on the final tick is an abort
        pulseManual(8'd1);
        repeat (TICK_DIV - 1) cyc();
        checkOutput("final_tick_rem", 32'(remaining), 1);
        applyStimulus(1'b0, 8'd0, 1'b1);
        cyc();
        applyStimulus(1'b0, 8'd0, 1'b0);
        modelAborts = (modelAborts < 255) ? modelAborts + 1 : 255;
        checkOutput("final_tick_state", 32'(state), 4);
        checkOutput("final_tick_no_done", 32'(cycle_done), 0);
        checkOutput("final_tick_aborts", 32'(abort_count), 32'(modelAborts));
        waitState(3'd0, 40, n);

        // Manual request on the period-expiry edge takes the manual path
        applyStimulus(1'b1, 8'd0, 1'b0);
        repeat (PERIOD_CYCLES - 1) cyc();
        pulseManual(8'd1);
        checkOutput("collide_state", 32'(state), 3);
        checkOutput("collide_no_sreq", 32'(sample_req), 0);
        applyStimulus(1'b0, 8'd0, 1'b0);
        cyc();
        checkOutput("manual_ignores_enable", 32'(state), 3);
        waitState(3'd0, 40, n);

        // Randomized aborts drive the counter into saturation
        for (int it = 0; it < 260; it++) begin
            m = $urandom_range(1, 4);
            abortAt = $urandom_range(0, m * TICK_DIV - 1);
            pulseManual(8'(m));
            repeat (abortAt) cyc();
            applyStimulus(1'b0, 8'd0, 1'b1);
            cyc();
            applyStimulus(1'b0, 8'd0, 1'b0);
            modelAborts = (modelAborts < 255) ? modelAborts + 1 : 255;
            checkOutput("sat_aborts", 32'(abort_count), 32'(modelAborts));
            checkOutput("sat_state", 32'(state), 4);
            waitState(3'd0, 40, n);
        end

        // Asynchronous reset in the middle of an irrigation
        pulseManual(8'd5);
        repeat (3) cyc();
        checkOutput("pre_reset_valve", 32'(valve_on), 1);
        reset = 1'b1;
        #1;
        checkOutput("async_valve", 32'(valve_on), 0);
        checkOutput("async_state", 32'(state), 0);
        checkOutput("async_remaining", 32'(remaining), 0);
        checkOutput("async_aborts", 32'(abort_count), 0);
        checkOutput("async_sreq", 32'(sample_req), 0);
        checkOutput("async_done", 32'(cycle_done), 0);
        cyc();
        reset = 1'b0;
        cyc();
        checkOutput("post_reset_state", 32'(state), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
